// File: rtl/seg_wr_arbiter.sv
// Round-robin write-port arbiter for the 8-digit seven-segment register file,
// with a clear sequencer that sweeps every digit to CLR_VAL.
module seg_wr_arbiter #(
    parameter int          NREQ    = 2,
    parameter logic [3:0]  CLR_VAL = 4'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_sel,
    input  logic [4*NREQ-1:0]   req_num,
    output logic [NREQ-1:0]     gnt,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic                write,
    output logic [2:0]          sel,
    output logic [3:0]          num
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  idx_q, idx_d;
    logic        write_q, write_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  num_q, num_d;
    logic        busy_q, busy_d;

    // Requester fields widened to a fixed 8-entry view so 3-bit indices fit exactly.
    logic [7:0]  req_pad;
    logic [2:0]  sel_arr [8];
    logic [3:0]  num_arr [8];

    assign req_pad = 8'(req);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NREQ) begin : g_used
                assign sel_arr[gi] = req_sel[3*gi +: 3];
                assign num_arr[gi] = req_num[4*gi +: 4];
            end else begin : g_unused
                assign sel_arr[gi] = 3'd0;
                assign num_arr[gi] = 4'd0;
            end
        end
    endgenerate

    logic        win_valid;
    logic [2:0]  win_idx;
    logic [3:0]  cand_sum;
    logic [3:0]  next_ptr;
    logic [7:0]  gnt_pad;

    // Scan from ptr upward, wrapping mod NREQ; first set request wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
        cand_sum  = 4'd0;
        gnt_pad   = 8'd0;
        if (state_q == IDLE && !clr_start && !reset) begin
            for (int off = 0; off < NREQ; off++) begin
                cand_sum = {1'b0, ptr_q} + 4'(off);
                if (cand_sum >= 4'(NREQ)) begin
                    cand_sum = cand_sum - 4'(NREQ);
                end
                if (!win_valid && req_pad[cand_sum[2:0]]) begin
                    win_valid = 1'b1;
                    win_idx   = cand_sum[2:0];
                end
            end
            if (win_valid) begin
                gnt_pad[win_idx] = 1'b1;
            end
        end
        next_ptr = {1'b0, win_idx} + 4'd1;
        if (next_ptr >= 4'(NREQ)) begin
            next_ptr = 4'd0;
        end
    end

    assign gnt = gnt_pad[NREQ-1:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        write_d = 1'b0;
        sel_d   = sel_q;
        num_d   = num_q;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    write_d = 1'b1;
                    sel_d   = 3'd0;
                    num_d   = CLR_VAL;
                    busy_d  = 1'b1;
                    idx_d   = 3'd1;
                    state_d = CLEAR;
                end else if (win_valid) begin
                    write_d = 1'b1;
                    sel_d   = sel_arr[win_idx];
                    num_d   = num_arr[win_idx];
                    ptr_d   = next_ptr[2:0];
                end
            end
            CLEAR: begin
                // The idx==7 write still counts as part of the sweep, so busy stays high.
                write_d = 1'b1;
                sel_d   = idx_q;
                num_d   = CLR_VAL;
                busy_d  = 1'b1;
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            write_q <= 1'b0;
            sel_q   <= 3'd0;
            num_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
        end
    end

    assign write    = write_q;
    assign sel      = sel_q;
    assign num      = num_q;
    assign clr_busy = busy_q;

endmodule

// File: tb/tb_seg_wr_arbiter.sv
// Randomized bench for seg_wr_arbiter against a transaction-level model:
// pending-item table per requester, a rotating pointer and a sweep countdown.
module tb_seg_wr_arbiter;

    localparam int         NREQ    = 3;
    localparam logic [3:0] CLR_VAL = 4'hC;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   req_sel;
    logic [4*NREQ-1:0]   req_num;
    logic [NREQ-1:0]     gnt;
    logic                clr_start;
    logic                clr_busy;
    logic                write;
    logic [2:0]          sel;
    logic [3:0]          num;

    seg_wr_arbiter #(.NREQ(NREQ), .CLR_VAL(CLR_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_sel   (req_sel),
        .req_num   (req_num),
        .gnt       (gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .write     (write),
        .sel       (sel),
        .num       (num)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit         pend [NREQ];
    logic [2:0] psel [NREQ];
    logic [3:0] pnum [NREQ];
    int         last_win = -1;
    int         ptr_m = 0;
    int         sweep_m = 0;
    logic       exp_write = 1'b0;
    logic [2:0] exp_sel = 3'd0;
    logic [3:0] exp_num = 4'd0;
    logic       exp_busy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("write",    32'(write),    32'(exp_write));
        check_val("sel",      32'(sel),      32'(exp_sel));
        check_val("num",      32'(num),      32'(exp_num));
        check_val("clr_busy", 32'(clr_busy), 32'(exp_busy));
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input int p_req, input int p_clr);
        logic [NREQ-1:0] eg;
        int              win;
        int              r;
        logic            clr;
        check_outputs();
        for (int i = 0; i < NREQ; i++) begin
            if (last_win == i) pend[i] = 1'b0;
            if (!pend[i] && int'($urandom_range(99)) < p_req) begin
                pend[i] = 1'b1;
                psel[i] = 3'($urandom);
                pnum[i] = 4'($urandom);
            end
        end
        clr = (int'($urandom_range(99)) < p_clr);
        for (int i = 0; i < NREQ; i++) begin
            req[i]           = pend[i];
            req_sel[3*i +: 3] = psel[i];
            req_num[4*i +: 4] = pnum[i];
        end
        clr_start = clr;
        #1;
        win = -1;
        if (sweep_m == 0 && !clr) begin
            for (int j = 0; j < NREQ; j++) begin
                r = (ptr_m + j) % NREQ;
                if (win < 0 && pend[r]) win = r;
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        check_val("gnt", 32'(gnt), 32'(eg));
        if (sweep_m > 0) begin
            exp_write = 1'b1;
            exp_sel   = 3'(8 - sweep_m);
            exp_num   = CLR_VAL;
            exp_busy  = 1'b1;
            sweep_m--;
        end else if (clr) begin
            exp_write = 1'b1;
            exp_sel   = 3'd0;
            exp_num   = CLR_VAL;
            exp_busy  = 1'b1;
            sweep_m   = 7;
        end else if (win >= 0) begin
            exp_write = 1'b1;
            exp_sel   = psel[win];
            exp_num   = pnum[win];
            exp_busy  = 1'b0;
            ptr_m     = (win + 1) % NREQ;
        end else begin
            exp_write = 1'b0;
            exp_busy  = 1'b0;
        end
        last_win = win;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic reset_mid();
        #2;
        req       = '0;
        clr_start = 1'b0;
        reset     = 1'b1;
        #1;
        ptr_m = 0; sweep_m = 0; last_win = -1;
        exp_write = 1'b0; exp_sel = 3'd0; exp_num = 4'd0; exp_busy = 1'b0;
        check_outputs();
        check_val("gnt_in_reset", 32'(gnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_sel   = '0;
        req_num   = '0;
        clr_start = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; psel[i] = 3'd0; pnum[i] = 4'd0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        check_val("gnt_reset", 32'(gnt), 32'd0);
        reset = 1'b0;

        // Single request after reset
        pend[0] = 1'b1; psel[0] = 3'd3; pnum[0] = 4'h9;
        repeat (3) step(0, 0);

        // Round robin with everyone requesting
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1; psel[i] = 3'(i + 1); pnum[i] = 4'(10 + i);
        end
        repeat (8) step(100, 0);
        repeat (4) step(0, 0);

        // Clear colliding with a request, then a restart attempt mid-sweep
        pend[1] = 1'b1; psel[1] = 3'd6; pnum[1] = 4'h7;
        step(0, 100);
        repeat (2) step(0, 0);
        step(0, 100);
        repeat (8) step(0, 0);

        // Reset after the sel=4 clear write
        step(0, 100);
        repeat (4) step(0, 0);
        reset_mid();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        pend[0] = 1'b1; psel[0] = 3'd2; pnum[0] = 4'h5;
        repeat (3) step(0, 0);

        // Randomized traffic at several loads
        repeat (600) step(30, 3);
        repeat (600) step(90, 5);
        repeat (600) step(60, 20);
        step(0, 100);
        repeat (3) step(50, 0);
        reset_mid();
        repeat (300) step(70, 10);
        repeat (10) step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_wr_arbiter.md
Name: seg_wr_arbiter

Overview:
- Write-port controller for the 8-digit seven-segment display block.
- That display block has a single write/sel/num port into its 8-entry digit register file.
- This block shares that port between NREQ requesters (for example the switch-entry path and an on-chip counter/message source) using round-robin arbitration.
- It also provides a clear sequencer that sweeps all 8 digits to a fixed value.
- It sits directly in front of the display block, in the same clock domain.

Parameters:
- NREQ, 2, number of write requesters (2..8).
- CLR_VAL, 4'h0, digit value written to every digit by the clear sweep.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request; held high until the matching gnt bit is seen.
- req_sel  input  3*NREQ  digit index, requester i in bits [3i+2:3i].
- req_num  input  4*NREQ  digit value, requester i in bits [4i+3:4i].
- gnt  output  NREQ  one-hot grant, combinational, valid in the decision cycle.
- clr_start  input  1  single-cycle pulse that starts a clear sweep.
- clr_busy  output  1  high while the clear sweep's writes are on the port.
- write  output  1  registered write strobe to the display block.
- sel  output  3  registered digit index to the display block.
- num  output  4  registered digit value to the display block.

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE, ptr=0, idx=0, write=0, sel=0, num=0, clr_busy=0, gnt=0.
- States:
  - IDLE: arbitration.
  - CLEAR: sweep in progress.
- IDLE, priority order per cycle:
  - clr_start beats any req. No gnt is asserted in that cycle.
  - Otherwise, if any req is high, pick the first set bit scanning from ptr upward, mod NREQ.
- IDLE grant, clock cycle k (requester i wins):
  - gnt[i]=1 combinationally in cycle k.
  - At the edge ending k: write<=1, sel<=req_sel[i], num<=req_num[i], ptr<=(i+1) mod NREQ.
  - Write latency is 1 cycle: write/sel/num are valid in cycle k+1.
- IDLE with no req and no clr_start: write<=0; sel and num hold their previous values.
- Requester handshake: the requester drops req (or presents its next item) at the edge ending the cycle in which it saw gnt. A req still high in the next cycle is a new request.
- Round-robin is strict: with all req bits high, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Clear start, clr_start seen in IDLE at cycle k: write<=1, sel<=0, num<=CLR_VAL, clr_busy<=1, idx<=1, state<=CLEAR.
- CLEAR state, each cycle:
  - write<=1, sel<=idx, num<=CLR_VAL, idx<=idx+1.
  - When idx==7: issue that write and set state<=IDLE. clr_busy stays high for that final write cycle and drops after it.
- Clear timing: writes occupy cycles k+1..k+8 with sel=0..7; clr_busy is high for exactly those 8 cycles.
- Requests during the sweep: gnt stays 0 while state=CLEAR. In cycle k+8 the state is already IDLE, so a pending req is granted there and its write appears in k+9, back-to-back with the sweep.
- clr_start while in CLEAR: ignored; the sweep does not restart and is not extended.
- ptr is unchanged by a clear sweep.
- Reset asserted mid-sweep: aborts immediately. All outputs return to their reset values and no further clear writes occur.
- req bits at index ≥ NREQ do not exist. An out-of-range req_sel is impossible because the field is 3 bits.

Test Plan:
- Reset then single request: reset high 2 cycles, then req=2'b01, req_sel[2:0]=3, req_num[3:0]=4'h9 → gnt=2'b01 in the same cycle; write=1, sel=3, num=9 one cycle later; write=0 afterwards once req drops.
- Round-robin fairness: hold req=2'b11 for 4 cycles with requester 0 at (1,4'hA) and requester 1 at (2,4'hB) → gnt sequence 01,10,01,10; writes (1,A),(2,B),(1,A),(2,B).
- Clear sweep: pulse clr_start with CLR_VAL=4'h0 → 8 consecutive write cycles with sel=0..7, num=0; clr_busy high for exactly those 8 cycles; gnt=0 throughout.
- Clear vs. request collision: clr_start and req=2'b10 in the same cycle → no gnt in that cycle; the sweep runs; gnt=2'b10 in the 8th sweep cycle; requester 1's write appears the cycle after the last clear write.
- Restart ignored: a second clr_start pulse 3 cycles into the sweep → still exactly 8 writes in total; clr_busy falls on schedule.
- Reset mid-sweep: assert reset after the write with sel=4 → write=0, sel=0, num=0, clr_busy=0 immediately (asynchronously); after release the block is idle; a req=2'b01 is then granted in its first cycle, confirming ptr=0.
